// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the shared-memory multi-cycle datapath
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   opcode               instruction opcode from IR (stable outside FETCH)
//   mem_ready            memory finishes the current access this cycle
//   PCWrite..RegDst      single-bit datapath controls
//   PCSource, ALUSrcB, ALUOp  2-bit datapath mux/ALU selects
//   instr_done           one-cycle pulse when an instruction retires
//   illegal_op           one-cycle pulse when an undefined opcode is trapped
//   state                current state encoding (debug)
module multicycle_control #(
    parameter int                    OPCODE_W = 7,
    parameter logic [OPCODE_W-1:0]   OP_RTYPE = 0,
    parameter logic [OPCODE_W-1:0]   OP_ADDI  = 8,
    parameter logic [OPCODE_W-1:0]   OP_LW    = 35,
    parameter logic [OPCODE_W-1:0]   OP_SW    = 43,
    parameter logic [OPCODE_W-1:0]   OP_BEQ   = 4,
    parameter logic [OPCODE_W-1:0]   OP_J     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                ALUSrcA,
    output logic                RegWrite,
    output logic                RegDst,
    output logic [1:0]          PCSource,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic                instr_done,
    output logic                illegal_op,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_ALU_WB_R  = 4'd9,
        S_ALU_WB_I  = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_TRAP      = 4'd13
    } state_e;

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                // PC+4 and IR load only commit once the instruction word arrives
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                PCWrite = mem_ready;
                IRWrite = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // speculative branch target computed while the opcode is decoded
                ALUSrcB = 2'b11;
                ALUOp   = 2'b10;
                if (opcode == OP_RTYPE)                        state_d = S_EXEC_R;
                else if (opcode == OP_ADDI)                    state_d = S_EXEC_I;
                else if (opcode == OP_LW || opcode == OP_SW)   state_d = S_MEM_ADDR;
                else if (opcode == OP_BEQ)                     state_d = S_BRANCH;
                else if (opcode == OP_J)                       state_d = S_JUMP;
                else                                           state_d = S_TRAP;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b10;
                state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                // a store retires in the cycle the memory accepts it
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                state_d = S_ALU_WB_R;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALU_WB_I;
            end
            S_ALU_WB_R: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ALU_WB_I: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                // the faulting instruction is dropped; no retirement is reported
                illegal_op = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, ALUSrcA, RegWrite, RegDst;
    logic [1:0] PCSource, ALUSrcB, ALUOp;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .instr_done(instr_done), .illegal_op(illegal_op),
        .state(state)
    );

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic       mr;
        logic [3:0] st;
    } vec_t;

    vec_t vecs[$];

    // Expected output word for a given state/mem_ready, straight from the state table.
    function automatic logic [21:0] exp_out(input logic [3:0] s, input logic mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, done, ill;
        logic [1:0] pcs, asb, aop;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, done, ill} = '0;
        pcs = 2'b00; asb = 2'b00; aop = 2'b00;
        case (s)
            4'd1:  begin mrd = 1; asb = 2'b01; aop = 2'b10; pcw = mr; irw = mr; end
            4'd2:  begin asb = 2'b11; aop = 2'b10; end
            4'd3:  begin asa = 1; asb = 2'b10; aop = 2'b10; end
            4'd4:  begin mrd = 1; iord = 1; end
            4'd5:  begin rw = 1; m2r = 1; done = 1; end
            4'd6:  begin mwr = 1; iord = 1; done = mr; end
            4'd7:  begin asa = 1; end
            4'd8:  begin asa = 1; asb = 2'b10; aop = 2'b10; end
            4'd9:  begin rw = 1; rd = 1; done = 1; end
            4'd10: begin rw = 1; done = 1; end
            4'd11: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
            4'd12: begin pcw = 1; pcs = 2'b10; done = 1; end
            4'd13: begin ill = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, asa, rw, rd, pcs, asb, aop, done, ill, s};
    endfunction

    function automatic logic [21:0] dut_out();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
                instr_done, illegal_op, state};
    endfunction

    task automatic check(input string name, input logic [21:0] exp);
        logic [21:0] act;
        act = dut_out();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got state=%0d outs=%h, want state=%0d outs=%h",
                     name, act[3:0], act[21:4], exp[3:0], exp[21:4]);
        end
    endtask

    task automatic add(input logic r, input logic [6:0] op, input logic mr, input logic [3:0] st);
        vec_t v;
        v.rst = r; v.op = op; v.mr = mr; v.st = st;
        vecs.push_back(v);
    endtask

    // Microstep route taken after FETCH for each opcode.
    int route[$];
    task automatic load_route(input logic [6:0] op);
        route.delete();
        case (op)
            7'd35:   route = '{2, 3, 4, 5};
            7'd43:   route = '{2, 3, 6};
            7'd0:    route = '{2, 7, 9};
            7'd8:    route = '{2, 8, 10};
            7'd4:    route = '{2, 11};
            7'd2:    route = '{2, 12};
            default: route = '{2, 13};
        endcase
    endtask

    function automatic logic [6:0] pick_op();
        logic [6:0] r;
        r = 7'($urandom);
        case ($urandom_range(0, 7))
            0: return 7'd35;
            1: return 7'd43;
            2: return 7'd0;
            3: return 7'd8;
            4: return 7'd4;
            5: return 7'd2;
            default: return r;
        endcase
    endfunction

    initial begin
        int cur;
        logic r, mr;

        // reset held for two edges
        reset = 1'b1; opcode = 7'd35; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("reset_hold%0d", i), exp_out(4'd0, 1'b1));
        end
        @(posedge clk); #1;

        // lw, no waits
        add(0, 35, 1, 0);
        add(0, 35, 1, 1); add(0, 35, 1, 2); add(0, 35, 1, 3); add(0, 35, 1, 4); add(0, 35, 1, 5);
        // sw with one fetch wait and two store waits
        add(0, 43, 0, 1); add(0, 43, 1, 1); add(0, 43, 1, 2); add(0, 43, 1, 3);
        add(0, 43, 0, 6); add(0, 43, 0, 6); add(0, 43, 1, 6);
        // R-type then addi
        add(0, 0, 1, 1); add(0, 0, 1, 2); add(0, 0, 1, 7); add(0, 0, 1, 9);
        add(0, 8, 1, 1); add(0, 8, 1, 2); add(0, 8, 1, 8); add(0, 8, 1, 10);
        // beq then j
        add(0, 4, 1, 1); add(0, 4, 1, 2); add(0, 4, 1, 11);
        add(0, 2, 1, 1); add(0, 2, 1, 2); add(0, 2, 1, 12);
        // illegal opcode, then fetch resumes
        add(0, 5, 1, 1); add(0, 5, 1, 2); add(0, 5, 1, 13);
        // sw interrupted by reset while stalled in MEM_WRITE
        add(0, 43, 1, 1); add(0, 43, 1, 2); add(0, 43, 1, 3);
        add(1, 43, 0, 6); add(0, 43, 0, 0); add(0, 43, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; opcode = vecs[i].op; mem_ready = vecs[i].mr;
            @(negedge clk);
            check($sformatf("vec%0d", i), exp_out(vecs[i].st, vecs[i].mr));
            @(posedge clk); #1;
        end

        // randomized run against the route model
        reset = 1'b1;
        @(posedge clk); #1;
        cur = 0;
        route.delete();
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 63) == 0);
            mr = ($urandom_range(0, 3) != 0);
            if (cur <= 1) opcode = pick_op();
            reset = r; mem_ready = mr;
            @(negedge clk);
            check($sformatf("rand%0d", i), exp_out(4'(cur), mr));
            if (r) begin
                cur = 0;
                route.delete();
            end else if ((cur == 1 || cur == 4 || cur == 6) && !mr) begin
                cur = cur;
            end else if (cur == 0) begin
                cur = 1;
            end else if (cur == 1) begin
                load_route(opcode);
                cur = route.pop_front();
            end else if (route.size() > 0) begin
                cur = route.pop_front();
            end else begin
                cur = 1;
            end
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
